surf_dout_align_ctrl: RTL and testbench

- Training sequencer for one SURF DOUT lane on the TURFIO. It drives the PHY's ISERDES reset, IDELAY value/load and bitslip.
- Sweeps all 64 IDELAY taps against a static training byte, finds the widest passing eye and loads its centre.
- Then bitslips until the deserialized byte equals the training pattern.
- Reports locked/fail status and the eye result to the control register space.

---
 rtl/surf_dout_align_ctrl_if.sv | 28 ++
 rtl/surf_dout_align_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_surf_dout_align_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/surf_dout_align_ctrl_if.sv
// Control/status bundle between the DOUT align sequencer and its PHY/register side.
// master = sequencer, slave = PHY and control-register side.
interface surf_dout_align_ctrl_if;
  logic       start_i;
  logic [7:0] dout_i;
  logic       iserdes_rst_o;
  logic [5:0] idelay_value_o;
  logic       idelay_load_o;
  logic       bitslip_o;
  logic       busy_o;
  logic       locked_o;
  logic       fail_o;
  logic [5:0] eye_start_o;
  logic [6:0] eye_width_o;
  logic [2:0] slip_count_o;

  modport master (
    input  start_i, dout_i,
    output iserdes_rst_o, idelay_value_o, idelay_load_o, bitslip_o,
           busy_o, locked_o, fail_o, eye_start_o, eye_width_o, slip_count_o
  );

  modport slave (
    output start_i, dout_i,
    input  iserdes_rst_o, idelay_value_o, idelay_load_o, bitslip_o,
           busy_o, locked_o, fail_o, eye_start_o, eye_width_o, slip_count_o
  );
endinterface

// File: rtl/surf_dout_align_ctrl.sv
// Training sequencer for one SURF DOUT lane: IDELAY eye sweep, centre load,
// then bitslip until the deserialized byte matches the training pattern.
module surf_dout_align_ctrl #(
  parameter logic [7:0]  TRAIN_PATTERN = 8'hA9,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CHECK_CYCLES  = 256,
  parameter int unsigned MIN_EYE       = 8
) (
  input  logic                        sysclk_i,
  input  logic                        rst_n_i,
  surf_dout_align_ctrl_if.master      bus
);

  localparam int unsigned CNT_W  = 17;
  localparam int unsigned TAP_W  = 6;
  localparam int unsigned WID_W  = 7;
  localparam int unsigned SLIP_W = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_ISRST, S_SET_TAP, S_LOAD_PRE, S_STROBE, S_SETTLE, S_CHECK,
    S_NEXT_TAP, S_EVAL, S_LOAD_CTR, S_SLIP_CHECK, S_LOCKED, S_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TAP_W-1:0]    tap_q, tap_d;
  logic [7:0]          ref_q, ref_d;
  logic                pass_q, pass_d;
  logic                aligning_q, aligning_d;
  logic [WID_W-1:0]    run_len_q, run_len_d, run_len_n;
  logic [TAP_W-1:0]    run_start_q, run_start_d, run_start_n;
  logic [WID_W-1:0]    best_w_q, best_w_d;
  logic [TAP_W-1:0]    best_s_q, best_s_d;

  logic                iserdes_rst_q, iserdes_rst_d;
  logic [TAP_W-1:0]    value_q, value_d;
  logic                load_q, load_d;
  logic                bitslip_q, bitslip_d;
  logic                busy_q, busy_d;
  logic                locked_q, locked_d;
  logic                fail_q, fail_d;
  logic [TAP_W-1:0]    eye_start_q, eye_start_d;
  logic [WID_W-1:0]    eye_width_q, eye_width_d;
  logic [SLIP_W-1:0]   slip_q, slip_d;

  // True when b is any of the 8 rotations of the training byte.
  function automatic logic is_rot(input logic [7:0] b);
    logic [15:0] dbl;
    logic        hit;
    dbl = {TRAIN_PATTERN, TRAIN_PATTERN};
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dbl[i +: 8] == b) hit = 1'b1;
    end
    return hit;
  endfunction

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tap_q         <= '0;
      ref_q         <= '0;
      pass_q        <= 1'b0;
      aligning_q    <= 1'b0;
      run_len_q     <= '0;
      run_start_q   <= '0;
      best_w_q      <= '0;
      best_s_q      <= '0;
      iserdes_rst_q <= 1'b0;
      value_q       <= '0;
      load_q        <= 1'b0;
      bitslip_q     <= 1'b0;
      busy_q        <= 1'b0;
      locked_q      <= 1'b0;
      fail_q        <= 1'b0;
      eye_start_q   <= '0;
      eye_width_q   <= '0;
      slip_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tap_q         <= tap_d;
      ref_q         <= ref_d;
      pass_q        <= pass_d;
      aligning_q    <= aligning_d;
      run_len_q     <= run_len_d;
      run_start_q   <= run_start_d;
      best_w_q      <= best_w_d;
      best_s_q      <= best_s_d;
      iserdes_rst_q <= iserdes_rst_d;
      value_q       <= value_d;
      load_q        <= load_d;
      bitslip_q     <= bitslip_d;
      busy_q        <= busy_d;
      locked_q      <= locked_d;
      fail_q        <= fail_d;
      eye_start_q   <= eye_start_d;
      eye_width_q   <= eye_width_d;
      slip_q        <= slip_d;
    end
  end

  // Strobes are registered from the transition into their one-cycle state, so they never overlap.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tap_d         = tap_q;
    ref_d         = ref_q;
    pass_d        = pass_q;
    aligning_d    = aligning_q;
    run_len_d     = run_len_q;
    run_start_d   = run_start_q;
    best_w_d      = best_w_q;
    best_s_d      = best_s_q;
    iserdes_rst_d = 1'b0;
    value_d       = value_q;
    load_d        = 1'b0;
    bitslip_d     = 1'b0;
    locked_d      = locked_q;
    fail_d        = fail_q;
    eye_start_d   = eye_start_q;
    eye_width_d   = eye_width_q;
    slip_d        = slip_q;
    run_len_n     = pass_q ? (run_len_q + WID_W'(1)) : '0;
    run_start_n   = (pass_q && (run_len_q == '0)) ? tap_q : run_start_q;

    case (state_q)
      S_IDLE, S_LOCKED, S_FAIL: begin
        if (bus.start_i) begin
          state_d       = S_ISRST;
          cnt_d         = '0;
          iserdes_rst_d = 1'b1;
          locked_d      = 1'b0;
          fail_d        = 1'b0;
          eye_start_d   = '0;
          eye_width_d   = '0;
          slip_d        = '0;
          aligning_d    = 1'b0;
          run_len_d     = '0;
          run_start_d   = '0;
          best_w_d      = '0;
          best_s_d      = '0;
        end
      end
      S_ISRST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = S_SET_TAP;
          cnt_d   = '0;
          tap_d   = '0;
        end else begin
          cnt_d         = cnt_q + CNT_W'(1);
          iserdes_rst_d = 1'b1;
        end
      end
      S_SET_TAP, S_LOAD_CTR: begin
        value_d = tap_q;
        state_d = S_LOAD_PRE;
      end
      S_LOAD_PRE: begin
        load_d  = 1'b1;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = aligning_q ? S_SLIP_CHECK : S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (cnt_q == '0) begin
          ref_d  = bus.dout_i;
          pass_d = is_rot(bus.dout_i);
        end else if (bus.dout_i != ref_q) begin
          pass_d = 1'b0;
        end
        if (cnt_q == CNT_W'(CHECK_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_NEXT_TAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_NEXT_TAP: begin
        run_len_d   = run_len_n;
        run_start_d = run_start_n;
        if (run_len_n > best_w_q) begin
          best_w_d = run_len_n;
          best_s_d = run_start_n;
        end
        if (tap_q == TAP_W'(63)) begin
          state_d = S_EVAL;
        end else begin
          tap_d   = tap_q + TAP_W'(1);
          state_d = S_SET_TAP;
        end
      end
      S_EVAL: begin
        eye_start_d = best_s_q;
        eye_width_d = best_w_q;
        if (best_w_q < WID_W'(MIN_EYE)) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          tap_d      = best_s_q + best_w_q[WID_W-1:1];
          aligning_d = 1'b1;
          state_d    = S_LOAD_CTR;
        end
      end
      S_SLIP_CHECK: begin
        if (bus.dout_i == TRAIN_PATTERN) begin
          locked_d = 1'b1;
          state_d  = S_LOCKED;
        end else if (slip_q == SLIP_W'(7)) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          bitslip_d = 1'b1;
          slip_d    = slip_q + SLIP_W'(1);
          state_d   = S_STROBE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = !(state_d inside {S_IDLE, S_LOCKED, S_FAIL});
  end

  assign bus.iserdes_rst_o  = iserdes_rst_q;
  assign bus.idelay_value_o = value_q;
  assign bus.idelay_load_o  = load_q;
  assign bus.bitslip_o      = bitslip_q;
  assign bus.busy_o         = busy_q;
  assign bus.locked_o       = locked_q;
  assign bus.fail_o         = fail_q;
  assign bus.eye_start_o    = eye_start_q;
  assign bus.eye_width_o    = eye_width_q;
  assign bus.slip_count_o   = slip_q;

endmodule

// File: tb/tb_surf_dout_align_ctrl.sv
// Bench for surf_dout_align_ctrl: a PHY model driven by a per-tap pass mask and
// rotation, with results checked against an eye/bitslip reference computed here.
module tb_surf_dout_align_ctrl;

  localparam logic [7:0] TRAIN  = 8'hA9;
  localparam int         RSTC   = 4;
  localparam int         SETTLE = 16;
  localparam int         CHECK  = 32;
  localparam int         MINEYE = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  surf_dout_align_ctrl_if bus ();

  surf_dout_align_ctrl #(
    .TRAIN_PATTERN(TRAIN), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETTLE),
    .CHECK_CYCLES(CHECK), .MIN_EYE(MINEYE)
  ) dut (
    .sysclk_i(clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scenario configuration, written by the stimulus block only.
  logic [63:0] cfg_mask = '0;
  int          cfg_rot = 0;
  bit          cfg_slip_eff = 1'b1;
  bit          cfg_bad_const = 1'b0;

  // PHY model / observation state, written by the PHY process only.
  int          cyc = 0;
  int          cur_tap = 0;
  int          cur_slips = 0;
  int          load_idx = 0;
  int          sweep_err = 0;
  int          hold_err = 0;
  int          excl_err = 0;
  int          bs_cnt = 0;
  int          last_bs = 0;
  int          min_gap = 1000;
  int          last_load = 0;
  logic [5:0]  prev_val = '0;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15 - n -: 8];
  endfunction

  function automatic logic [63:0] run_mask(input int s, input int len);
    logic [63:0] m;
    m = '0;
    for (int i = s; i < s + len; i++) if (i < 64) m[i] = 1'b1;
    return m;
  endfunction

  // PHY: IDELAY tap latched on load, bitslip rotates the presented pattern.
  always @(negedge clk) begin
    cyc++;
    if (bus.iserdes_rst_o) begin
      cur_slips = 0; load_idx = 0; sweep_err = 0; hold_err = 0;
      bs_cnt = 0; min_gap = 1000; last_load = 0;
    end
    if (int'(bus.iserdes_rst_o) + int'(bus.idelay_load_o) + int'(bus.bitslip_o) > 1) excl_err++;
    if (bus.idelay_load_o) begin
      if (bus.idelay_value_o != prev_val) hold_err++;
      if (load_idx < 64 && int'(bus.idelay_value_o) != load_idx) sweep_err++;
      cur_tap   = int'(bus.idelay_value_o);
      last_load = int'(bus.idelay_value_o);
      load_idx++;
    end
    if (bus.bitslip_o) begin
      if (bs_cnt > 0 && (cyc - last_bs) < min_gap) min_gap = cyc - last_bs;
      last_bs = cyc;
      bs_cnt++;
      if (cfg_slip_eff) cur_slips++;
    end
    prev_val = bus.idelay_value_o;
    if (cfg_mask[cur_tap]) bus.dout_i = rotl(TRAIN, (cfg_rot + 8 - (cur_slips % 8)) % 8);
    else if (cfg_bad_const) bus.dout_i = 8'h00;
    else bus.dout_i = 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Reference: widest run of passing taps (lowest start on ties), then the slips needed.
  task automatic ref_model(input logic [63:0] mask, input int rot, input bit slip_eff,
                           output int w, output int s, output int ctr,
                           output bit lock, output bit eye_ok, output int slips);
    int run;
    w = 0; s = 0; run = 0;
    for (int t = 0; t < 64; t++) begin
      run = mask[t] ? run + 1 : 0;
      if (run > w) begin w = run; s = t - run + 1; end
    end
    ctr    = s + w / 2;
    eye_ok = (w >= MINEYE);
    if (!eye_ok)            begin lock = 0; slips = 0;   end
    else if (slip_eff)      begin lock = 1; slips = rot; end
    else if (rot == 0)      begin lock = 1; slips = 0;   end
    else                    begin lock = 0; slips = 7;   end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start_i = 1'b1;
    @(negedge clk) bus.start_i = 1'b0;
  endtask

  task automatic run_case(input string name, input logic [63:0] mask, input int rot,
                          input bit slip_eff, input bit bad, input bit poke);
    int w, s, ctr, slips;
    bit lock, eye_ok, done;
    cfg_mask = mask; cfg_rot = rot; cfg_slip_eff = slip_eff; cfg_bad_const = bad;
    pulse_start();
    chk({name, "/entry_status"}, {bus.locked_o, bus.fail_o, bus.slip_count_o, bus.eye_width_o}, 0);
    chk({name, "/entry_isrst"}, {bus.iserdes_rst_o, bus.busy_o}, 2'b11);
    if (poke) begin
      repeat (300) @(negedge clk);
      pulse_start();
      chk({name, "/poke_isrst"}, bus.iserdes_rst_o, 0);
      chk({name, "/poke_busy"}, bus.busy_o, 1);
    end
    done = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!bus.busy_o) begin done = 1'b1; break; end
    end
    chk({name, "/finished"}, done, 1);
    ref_model(mask, rot, slip_eff, w, s, ctr, lock, eye_ok, slips);
    chk({name, "/eye_width"}, bus.eye_width_o, w);
    chk({name, "/eye_start"}, bus.eye_start_o, s);
    chk({name, "/locked"}, bus.locked_o, lock);
    chk({name, "/fail"}, bus.fail_o, !lock);
    chk({name, "/slip_count"}, bus.slip_count_o, slips);
    chk({name, "/bitslips"}, bs_cnt, slips);
    chk({name, "/loads"}, load_idx, eye_ok ? 65 : 64);
    chk({name, "/sweep_order"}, sweep_err, 0);
    chk({name, "/value_hold"}, hold_err, 0);
    chk({name, "/strobe_excl"}, excl_err, 0);
    if (eye_ok) chk({name, "/centre"}, last_load, ctr);
    if (bs_cnt > 1) chk({name, "/slip_gap"}, min_gap >= SETTLE + 1, 1);
  endtask

  initial begin
    logic [63:0] m;
    bit          reached;
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset/outputs", {bus.iserdes_rst_o, bus.idelay_value_o, bus.idelay_load_o, bus.bitslip_o,
                          bus.busy_o, bus.locked_o, bus.fail_o, bus.eye_start_o,
                          bus.eye_width_o, bus.slip_count_o}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset/idle", bus.busy_o, 0);

    run_case("clean", run_mask(20, 16), $urandom_range(0, 7), 1'b1, 1'b0, 1'b0);
    run_case("slip3", run_mask($urandom_range(0, 40), $urandom_range(8, 20)), 3, 1'b1, 1'b0, 1'b0);
    run_case("two_eyes", run_mask(5, 10) | run_mask(40, 10), $urandom_range(0, 7), 1'b1, 1'b0, 1'b1);
    run_case("narrow", run_mask(0, 5), $urandom_range(0, 7), 1'b1, 1'b0, 1'b0);
    run_case("all_pass", '1, $urandom_range(0, 7), 1'b1, 1'b0, 1'b0);
    run_case("const00", '0, 0, 1'b1, 1'b1, 1'b0);
    run_case("no_slip", run_mask(10, 20), $urandom_range(1, 7), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      m = '0;
      repeat ($urandom_range(1, 3)) m |= run_mask($urandom_range(0, 63), $urandom_range(1, 24));
      run_case($sformatf("rand%0d", k), m, $urandom_range(0, 7), 1'b1, 1'b0, 1'b0);
    end

    // Abort in the middle of a CHECK window with an asynchronous reset.
    cfg_mask = run_mask(0, 64); cfg_rot = 0; cfg_slip_eff = 1'b1; cfg_bad_const = 1'b0;
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (load_idx >= 10) begin reached = 1'b1; break; end
    end
    chk("abort/reached_tap10", reached, 1);
    repeat (SETTLE + 4) @(negedge clk);
    chk("abort/busy_before", bus.busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort/outputs", {bus.iserdes_rst_o, bus.idelay_value_o, bus.idelay_load_o, bus.bitslip_o,
                          bus.busy_o, bus.locked_o, bus.fail_o, bus.eye_start_o,
                          bus.eye_width_o, bus.slip_count_o}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort/stays_idle", {bus.busy_o, bus.iserdes_rst_o, bus.idelay_load_o}, 0);

    run_case("after_abort", run_mask(30, 12), $urandom_range(0, 7), 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
